// File: rtl/rect_coord_gen.sv
// Pseudo-random red/blue rectangle corner generator. An LFSR fills a shadow set over
// eight cycles; the set is committed to the outputs on a frame tick every HOLD_FRAMES frames.
module rect_coord_gen #(
  parameter int          H_MAX       = 640,
  parameter int          V_MAX       = 480,
  parameter int          MIN_SIZE    = 16,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  output logic [9:0] rw0_out,
  output logic [9:0] rw1_out,
  output logic [8:0] rh0_out,
  output logic [8:0] rh1_out,
  output logic [9:0] bw0_out,
  output logic [9:0] bw1_out,
  output logic [8:0] bh0_out,
  output logic [8:0] bh1_out,
  output logic       new_set
);

  localparam int          CW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [9:0]  X_BOUND   = 10'(H_MAX);
  localparam logic [8:0]  Y_BOUND   = 9'(V_MAX);
  localparam logic [9:0]  X_HALF    = 10'(H_MAX / 2);
  localparam logic [9:0]  Y_HALF    = 10'(V_MAX / 2);
  localparam logic [9:0]  MIN10     = 10'(MIN_SIZE);
  localparam logic [10:0] MIN11     = 11'(MIN_SIZE);

  typedef enum logic {S_GEN = 1'b0, S_READY = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_lfsr;
  logic [2:0]          r_step;
  logic [CW-1:0]       r_cnt;
  logic [3:0][9:0]     r_shx, r_outx;   // index {blue, edgeB}
  logic [3:0][8:0]     r_shy, r_outy;
  logic                r_new_set;

  logic                w_tick, w_commit, w_isy, w_close;
  logic [1:0]          w_idx, w_aidx;
  logic [9:0]          w_xv, w_v, w_a, w_half, w_fix, w_draw;
  logic [8:0]          w_yv;
  logic signed [10:0]  w_diff;
  logic [10:0]         w_abs;

  assign w_tick = frame_tick & enable;

  // Step k: bit2 = colour, bit1 = y axis, bit0 = B edge.
  assign w_isy  = r_step[1];
  assign w_idx  = {r_step[2], r_step[0]};
  assign w_aidx = {r_step[2], 1'b0};

  assign w_xv   = (r_lfsr[9:0] >= X_BOUND) ? r_lfsr[9:0] - X_BOUND : r_lfsr[9:0];
  assign w_yv   = (r_lfsr[8:0] >= Y_BOUND) ? r_lfsr[8:0] - Y_BOUND : r_lfsr[8:0];
  assign w_v    = w_isy ? {1'b0, w_yv} : w_xv;
  assign w_a    = w_isy ? {1'b0, r_shy[w_aidx]} : r_shx[w_aidx];
  assign w_half = w_isy ? Y_HALF : X_HALF;

  // B edge too close to A is pushed MIN_SIZE away, toward the middle of the screen.
  assign w_diff  = $signed({1'b0, w_v}) - $signed({1'b0, w_a});
  assign w_abs   = w_diff[10] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_close = (w_abs < MIN11);
  assign w_fix   = (w_a >= w_half) ? w_a - MIN10 : w_a + MIN10;
  assign w_draw  = (r_step[0] && w_close) ? w_fix : w_v;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_GEN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_GEN:   if (r_step == 3'd7) w_state_nxt = S_READY;
      S_READY: if (w_tick && r_cnt == CNT_LAST) begin
        w_commit    = 1'b1;
        w_state_nxt = S_GEN;
      end
      default: w_state_nxt = S_GEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr    <= LFSR_INIT;
      r_step    <= 3'd0;
      r_cnt     <= '0;
      r_shx     <= '0;
      r_shy     <= '0;
      r_outx    <= '0;
      r_outy    <= '0;
      r_new_set <= 1'b0;
    end else begin
      r_new_set <= w_commit;
      if (r_state == S_GEN) begin
        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        r_step <= r_step + 3'd1;
        if (w_isy) r_shy[w_idx] <= w_draw[8:0];
        else       r_shx[w_idx] <= w_draw;
        if (w_tick && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
      end else if (w_tick) begin
        if (w_commit) begin
          r_cnt  <= '0;
          r_outx <= r_shx;
          r_outy <= r_shy;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign rw0_out = r_outx[0];
  assign rw1_out = r_outx[1];
  assign bw0_out = r_outx[2];
  assign bw1_out = r_outx[3];
  assign rh0_out = r_outy[0];
  assign rh1_out = r_outy[1];
  assign bh0_out = r_outy[2];
  assign bh1_out = r_outy[3];
  assign new_set = r_new_set;

endmodule
